// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: echo/delay controller that drives an external delay buffer.
// Each accepted sample reads the delayed tap, writes the new sample, then mixes
// y = x + (delayed * gain) >>> 3 with saturation to DATA_WIDTH bits.
// Optional macro DELAY_LINE_FEEDBACK_EN: the mix result, not the raw input,
// is written back to the buffer (recirculating echo); the mix then runs before the write.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic [3:0]            gain,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_out_valid,
    output logic                  overrun,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_offset,
    output logic                  ram_wr,
    output logic                  ram_rd,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_write_finish,
    input  logic                  ram_read_finish,
    input  logic                  ram_available
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        MIX,
        OUT
    } state_t;

    localparam int MW = DATA_WIDTH + 5;
    localparam logic signed [MW-1:0] SAT_MAX = {{6{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [MW-1:0] SAT_MIN = {{6{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

`ifdef DELAY_LINE_FEEDBACK_EN
    // Recirculating echo: the mix must exist before it can be written back.
    localparam state_t AFTER_READ  = MIX;
    localparam state_t AFTER_MIX   = WR_REQ;
    localparam state_t AFTER_WRITE = OUT;
`else
    // Single-tap echo: the raw sample is stored, mixing happens last.
    localparam state_t AFTER_READ  = WR_REQ;
    localparam state_t AFTER_MIX   = OUT;
    localparam state_t AFTER_WRITE = MIX;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   sampleX_q, sampleX_d;
    logic [DATA_WIDTH-1:0]   delayed_q, delayed_d;
    logic [DATA_WIDTH-1:0]   sampleOut_q, sampleOut_d;
    logic [ADDR_WIDTH-1:0]   delay_q, delay_d;
    logic [3:0]              gain_q, gain_d;
    logic                    overrun_q, overrun_d;

    logic signed [MW-1:0]    delayedExt, gainExt, sampleExt;
    logic signed [MW-1:0]    mixProduct, mixShift, mixSum;
    logic [DATA_WIDTH-1:0]   mixSat;
    logic [DATA_WIDTH-1:0]   writeValue;

    // Echo arithmetic: widened signed multiply-shift-add, then clamp to the sample range.
    always_comb begin
        delayedExt = {{5{delayed_q[DATA_WIDTH-1]}}, delayed_q};
        gainExt    = {{(MW-4){1'b0}}, gain_q};
        sampleExt  = {{5{sampleX_q[DATA_WIDTH-1]}}, sampleX_q};
        mixProduct = delayedExt * gainExt;
        mixShift   = mixProduct >>> 3;
        mixSum     = sampleExt + mixShift;
        if (mixSum > SAT_MAX) begin
            mixSat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (mixSum < SAT_MIN) begin
            mixSat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            mixSat = mixSum[DATA_WIDTH-1:0];
        end
`ifdef DELAY_LINE_FEEDBACK_EN
        writeValue = sampleOut_q;
`else
        writeValue = sampleX_q;
`endif
    end

    // Next-state and buffer request logic; requests only ever come from RD_REQ/WR_REQ.
    always_comb begin
        state_d          = state_q;
        sampleX_d        = sampleX_q;
        delayed_d        = delayed_q;
        sampleOut_d      = sampleOut_q;
        delay_d          = delay_q;
        gain_d           = gain_q;
        overrun_d        = overrun_q | (sample_valid && (state_q != IDLE));
        ram_rd           = 1'b0;
        ram_wr           = 1'b0;
        ram_offset       = '0;
        ram_data_in      = '0;
        sample_out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    sampleX_d = sample_in;
                    delay_d   = delay;
                    gain_d    = gain;
                    delayed_d = '0;
                    state_d   = (delay == '0) ? AFTER_READ : RD_REQ;
                end
            end
            RD_REQ: begin
                if (ram_available) begin
                    ram_rd     = 1'b1;
                    ram_offset = delay_q;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ram_read_finish) begin
                    delayed_d = ram_data_out;
                    state_d   = AFTER_READ;
                end
            end
            WR_REQ: begin
                if (ram_available) begin
                    ram_wr      = 1'b1;
                    ram_data_in = writeValue;
                    state_d     = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (ram_write_finish) begin
                    state_d = AFTER_WRITE;
                end
            end
            MIX: begin
                sampleOut_d = mixSat;
                state_d     = AFTER_MIX;
            end
            OUT: begin
                sample_out_valid = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-operand registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sampleX_q   <= '0;
            delayed_q   <= '0;
            sampleOut_q <= '0;
            delay_q     <= '0;
            gain_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleX_q   <= sampleX_d;
            delayed_q   <= delayed_d;
            sampleOut_q <= sampleOut_d;
            delay_q     <= delay_d;
            gain_q      <= gain_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample_out = sampleOut_q;
    assign overrun    = overrun_q;

endmodule
